spi_ram_slave_p: RTL
====================

SPI_RAM_SLAVE_P -- requirements
Module: spi_ram_slave_p

Parameters
REQ-001 DATA_W, default 8, SHALL set the payload and memory word width in bits; legal values are 4 to 32.
REQ-002 ADDR_W, default 8, SHALL set the address width; legal values satisfy ADDR_W <= DATA_W.
REQ-003 DEPTH SHALL be a localparam fixed at 2**ADDR_W words.

Interface
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 SS_n  in  1  SHALL be the slave select, active-low; a frame lasts while it is low.
REQ-007 MOSI  in  1  SHALL be the serial data in, sampled on the rising clk edge.
REQ-008 MISO  out  1  SHALL be the serial data out, registered.
REQ-009 busy  out  1  SHALL be registered and high whenever state != IDLE.
REQ-010 abort  out  1  SHALL be a registered one-cycle pulse on an incomplete frame.

Function
REQ-011 The FSM SHALL have the states IDLE, CMD, RX, TX_WAIT, TX and DONE.
REQ-012 IDLE: the first edge with SS_n=0 SHALL go to CMD without sampling MOSI (start cycle).
REQ-013 CMD: the next 2 edges SHALL sample MOSI MSB-first into cmd[1:0].
- 00 WR_ADDR, 01 WR_DATA and 10 RD_ADDR go to RX.
- 11 RD_DATA goes to TX_WAIT.
REQ-014 RX: the next DATA_W edges SHALL shift MOSI MSB-first into the payload; on the last edge the command executes and the state goes to DONE.
REQ-015 WR_ADDR SHALL load wr_addr <= payload[ADDR_W-1:0]; upper payload bits are ignored.
REQ-016 RD_ADDR SHALL load rd_addr <= payload[ADDR_W-1:0]; upper payload bits are ignored.
REQ-017 WR_DATA SHALL write mem[wr_addr] <= payload and then increment wr_addr modulo DEPTH (DEPTH-1 wraps to 0).
REQ-018 TX_WAIT SHALL last exactly one cycle with MOSI ignored.
- Its exit edge loads tx_shift <= mem[rd_addr] and drives MISO <= mem[rd_addr][DATA_W-1].
- The state then goes to TX.
REQ-019 TX: each of the next DATA_W-1 edges SHALL drive MISO with the next lower bit; each bit is held exactly one cycle and MOSI is ignored.
REQ-020 The edge after bit 0 has been held SHALL set MISO to 0, increment rd_addr modulo DEPTH and go to DONE.
- Read latency: the MSB appears 1 cycle after the last cmd bit is sampled.
REQ-021 DONE SHALL ignore MOSI until SS_n=1 is sampled, then go to IDLE with no abort.
REQ-022 SS_n=1 sampled in CMD, RX, TX_WAIT or TX SHALL go to IDLE on that edge and pulse abort for one cycle.
- Memory and both address pointers are left unchanged.
- MISO is forced to 0.
REQ-023 SS_n=1 sampled in IDLE SHALL keep the state in IDLE.
REQ-024 MISO SHALL be 0 in every state except TX_WAIT-exit and TX.
REQ-025 wr_addr and rd_addr SHALL be independent; a WR_DATA burst never moves rd_addr, and the reverse also holds.
REQ-026 Back-to-back frames SHALL need at least one sampled SS_n=1 cycle between them.

Reset
REQ-027 While rst=1 the block SHALL immediately force the following, regardless of clk:
- state = IDLE
- MISO = 0, busy = 0, abort = 0
- wr_addr = 0, rd_addr = 0
- payload, cmd and tx_shift = 0
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 An rst assertion mid-frame SHALL discard the frame without writing memory and without pulsing abort.
REQ-030 After rst deasserts, the first edge with SS_n=0 SHALL be treated as a start cycle (REQ-012).

Verification (DATA_W=8, ADDR_W=8 unless stated)
REQ-031 Write and read back SHALL be covered: WR_ADDR 0x05, WR_DATA 0xA5, RD_ADDR 0x05, RD_DATA.
- MISO = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, starting 1 cycle after the last cmd bit.
- MISO = 0 afterwards.
- rd_addr = 0x06.
REQ-032 Write wrap-around SHALL be covered: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22.
- mem[0xFF] = 0x11, mem[0x00] = 0x22, wr_addr = 0x01.
- Reading back from RD_ADDR 0xFF returns 0x11 and then 0x22.
REQ-033 Abort SHALL be covered: WR_ADDR 0x10, then WR_DATA with SS_n raised after 3 payload bits.
- abort = 1 for exactly one cycle.
- mem[0x10] is unchanged and wr_addr = 0x10.
- The next full frame works normally.
REQ-034 Reset mid-TX SHALL be covered: rst pulsed during bit 4 of RD_DATA.
- MISO = 0, busy = 0 and rd_addr = 0 immediately (asynchronously).
- abort stays 0.
REQ-035 Reconfiguration SHALL be covered with DATA_W=16, ADDR_W=4: WR_ADDR 0x000F, WR_DATA 0xBEEF, WR_DATA 0x1234.
- mem[15] = 0xBEEF, mem[0] = 0x1234.
- RD_ADDR 0x000F followed by RD_DATA shifts out 0xBEEF MSB-first over 16 cycles.
REQ-036 Trailing bits SHALL be covered: SS_n held low 5 extra cycles after a complete WR_DATA.
- No second write occurs.
- busy stays 1 until SS_n=1 is sampled, then drops to 0.

Source files
------------

// File: rtl/spi_ram_slave_p.sv
// SPI-style RAM slave: 2-bit command followed by a DATA_W payload (writes) or a DATA_W readout (reads).
// Write and read pointers auto-increment independently; memory contents survive reset.
module spi_ram_slave_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic abort
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, CMD, RX, TX_WAIT, TX, DONE} state_t;

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0] cmd, cmd_nx;
  logic [DATA_W-1:0] payload, payload_nx, tx_shift, tx_shift_nx, rx_word;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nx, rd_addr, rd_addr_nx;
  logic miso_nx, abort_nx, mem_we;
  logic [DATA_W-1:0] mem [DEPTH];

  // Payload including the bit being sampled on this edge, so the command can execute on the last edge.
  assign rx_word = (payload << 1) | DATA_W'(MOSI);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    cmd_nx      = cmd;
    payload_nx  = payload;
    tx_shift_nx = tx_shift;
    wr_addr_nx  = wr_addr;
    rd_addr_nx  = rd_addr;
    miso_nx     = 1'b0;
    abort_nx    = 1'b0;
    mem_we      = 1'b0;
    if ((state inside {CMD, RX, TX_WAIT, TX}) && SS_n) begin
      state_nx = IDLE;
      abort_nx = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!SS_n) begin
            state_nx = CMD;
            cnt_nx   = '0;
          end
        end
        CMD: begin
          cmd_nx = {cmd[0], MOSI};
          if (cnt == CMD_LAST) begin
            cnt_nx   = '0;
            state_nx = ({cmd[0], MOSI} == 2'b11) ? TX_WAIT : RX;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        RX: begin
          payload_nx = rx_word;
          if (cnt == LAST) begin
            state_nx = DONE;
            case (cmd)
              2'b00: wr_addr_nx = rx_word[ADDR_W-1:0];
              2'b10: rd_addr_nx = rx_word[ADDR_W-1:0];
              2'b01: begin
                mem_we     = 1'b1;
                wr_addr_nx = wr_addr + 1'b1;
              end
              default: ;
            endcase
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        TX_WAIT: begin
          tx_shift_nx = mem[rd_addr];
          miso_nx     = mem[rd_addr][DATA_W-1];
          cnt_nx      = '0;
          state_nx    = TX;
        end
        TX: begin
          // The final edge only retires the frame; the LSB has already been held for a cycle.
          if (cnt == LAST) begin
            state_nx   = DONE;
            rd_addr_nx = rd_addr + 1'b1;
          end else begin
            miso_nx     = tx_shift[DATA_W-2];
            tx_shift_nx = tx_shift << 1;
            cnt_nx      = cnt + 1'b1;
          end
        end
        DONE: begin
          if (SS_n) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cmd      <= '0;
      payload  <= '0;
      tx_shift <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      MISO     <= 1'b0;
      busy     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cmd      <= cmd_nx;
      payload  <= payload_nx;
      tx_shift <= tx_shift_nx;
      wr_addr  <= wr_addr_nx;
      rd_addr  <= rd_addr_nx;
      MISO     <= miso_nx;
      busy     <= (state_nx != IDLE);
      abort    <= abort_nx;
    end
  end

  // Storage is deliberately left out of the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= rx_word;
  end

endmodule
